cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, using the decoder's control outputs. It drives the memory request handshakes and the PC, IR and register-file write enables. It also keeps cycle and retired-instruction counters, and has a sticky fault/halt mechanism for bring-up.

---
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/writeback,
// memory request handshakes, PC/IR/RF write strobes, cycle/instret counters, sticky halt/fault.
module cpu_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             reg_we,
  input  logic             illegal,
  input  logic             halt_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Handshake: a request stays high every cycle of FETCH/MEM until the matching
  // ready is seen high in the same cycle; that cycle completes the transfer.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [15:0]      WAIT_MAX = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [15:0]      r_wait;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;
  logic             w_timeout;

  assign w_timeout = (r_wait == WAIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 16'd0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (r_state != S_HALT && r_state != S_FAULT)
        r_cycle <= r_cycle + CNT_ONE;
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_wait  <= 16'd0;
        end
        S_FETCH: begin
          if (imem_ready)     r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_FAULT;
          else                r_wait  <= r_wait + 16'd1;
        end
        S_DECODE: r_state <= illegal ? S_FAULT : S_EXEC;
        S_EXEC: begin
          if (is_load || is_store) begin
            r_state <= S_MEM;
            r_wait  <= 16'd0;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready)     r_state <= S_WB;
          else if (w_timeout) r_state <= S_FAULT;
          else                r_wait  <= r_wait + 16'd1;
        end
        S_WB: begin
          r_instret <= r_instret + CNT_ONE;
          if (halt_req) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_FETCH;
            r_wait  <= 16'd0;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Strobes depend on the live ready/decoder inputs so a zero-wait access costs no extra cycle.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = reg_we;
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign halted      = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);
  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction reference model builds the
// expected cycle-by-cycle trace from the sequencing rules; directed cases plus random instructions.
module tb_cpu_sequencer;

  localparam int CW = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0, reg_we = 1'b0, illegal = 1'b0, halt_req = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, fault;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(CW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .is_load(is_load), .is_store(is_store), .reg_we(reg_we),
    .illegal(illegal), .halt_req(halt_req), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .state(state), .halted(halted), .fault(fault),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_cyc   = 0;
  int m_ret   = 0;
  logic [31:0] exp_q[$];

  // Strobe bundle: {imem_req,dmem_req,dmem_we,ir_we,pc_we,rf_we,halted,fault}
  logic [7:0] w_strb;
  assign w_strb = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic noise();
    imem_ready = 1'($urandom_range(0, 1));
    dmem_ready = 1'($urandom_range(0, 1));
    halt_req   = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1 with inputs set; checks the cycle at negedge, advances model.
  task automatic tick(input logic [2:0] es, input logic [7:0] eb);
    logic [31:0] e;
    exp_q.push_back({21'd0, es, eb});
    @(negedge clk);
    e = exp_q.pop_front();
    check("state", 32'(state), 32'(e[10:8]));
    check("strobes", 32'(w_strb), 32'(e[7:0]));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc % (1 << CW)));
    check("instret_cnt", 32'(instret_cnt), 32'(m_ret % (1 << CW)));
    if (es != 3'd6 && es != 3'd7) m_cyc++;
    if (es == 3'd5) m_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", 32'(w_strb), 32'd0);
    check("rst_counters", 32'({cycle_cnt, instret_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cyc = 0;
    m_ret = 0;
    noise();
    tick(3'd0, 8'h00);
  endtask

  // fate: 0 back to FETCH, 1 HALT, 2 FAULT, 3 reset applied mid-MEM
  task automatic run_instr(input int kind, input int iw, input int dw, input bit ill,
                           input bit hlt, input bit rwe, input bit rst_mid, output int fate);
    logic [7:0] mem_b;
    is_load  = (kind == 1);
    is_store = (kind == 2);
    reg_we   = rwe;
    illegal  = ill;
    fate     = 0;
    for (int w = 0; ; w++) begin
      noise();
      if (w < iw) begin
        imem_ready = 1'b0;
        tick(3'd1, 8'h80);
        if (w == TO) begin fate = 2; return; end
      end else begin
        imem_ready = 1'b1;
        tick(3'd1, 8'h90);
        break;
      end
    end
    noise();
    tick(3'd2, 8'h00);
    if (ill) begin fate = 2; return; end
    noise();
    tick(3'd3, 8'h00);
    if (kind != 0) begin
      mem_b = (kind == 2) ? 8'h60 : 8'h40;
      for (int w = 0; ; w++) begin
        noise();
        if (w < dw) begin
          dmem_ready = 1'b0;
          if (rst_mid && w == 1) begin
            @(negedge clk);
            check("mem_req_pre_rst", 32'(dmem_req), 32'd1);
            #2;
            apply_reset();
            fate = 3;
            return;
          end
          tick(3'd4, mem_b);
          if (w == TO) begin fate = 2; return; end
        end else begin
          dmem_ready = 1'b1;
          tick(3'd4, mem_b);
          break;
        end
      end
    end
    noise();
    halt_req = hlt;
    tick(3'd5, rwe ? 8'h0C : 8'h08);
    fate = hlt ? 1 : 0;
  endtask

  task automatic finish_fate(input int fate);
    if (fate == 1 || fate == 2) begin
      for (int k = 0; k < 3; k++) begin
        noise();
        if (fate == 1) tick(3'd6, 8'h02);
        else           tick(3'd7, 8'h01);
      end
      apply_reset();
    end
  endtask

  initial begin
    int fate, kind, iw, dw;
    bit ill, hlt, rwe;
    #1;
    apply_reset();
    run_instr(0, 0, 0, 0, 0, 1, 0, fate); finish_fate(fate);
    run_instr(1, 0, 3, 0, 0, 1, 0, fate); finish_fate(fate);
    run_instr(2, 0, 0, 0, 0, 0, 0, fate); finish_fate(fate);
    run_instr(0, TO, 0, 0, 0, 1, 0, fate); finish_fate(fate);
    run_instr(0, TO + 1, 0, 0, 0, 1, 0, fate);
    check("fetch_timeout_fault", 32'(fate), 32'd2);
    finish_fate(fate);
    run_instr(1, 0, TO, 0, 0, 1, 0, fate); finish_fate(fate);
    run_instr(2, 0, TO + 1, 0, 0, 0, 0, fate); finish_fate(fate);
    run_instr(0, 0, 0, 0, 0, 1, 0, fate); finish_fate(fate);
    run_instr(0, 1, 0, 1, 0, 1, 0, fate); finish_fate(fate);
    run_instr(0, 0, 0, 0, 0, 1, 0, fate); finish_fate(fate);
    run_instr(0, 0, 0, 0, 1, 1, 0, fate); finish_fate(fate);
    run_instr(1, 0, 3, 0, 0, 1, 1, fate);
    for (int i = 0; i < 16; i++) begin
      run_instr(0, 0, 0, 0, 0, 1, 0, fate);
    end
    check("instret_wrap", 32'(instret_cnt), 32'd0);
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      iw   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 1);
      dw   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
      ill  = ($urandom_range(0, 15) == 0);
      hlt  = ($urandom_range(0, 15) == 0);
      rwe  = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      run_instr(kind, iw, dw, ill, hlt, rwe, (kind != 0 && dw >= 2 && $urandom_range(0, 15) == 0), fate);
      finish_fate(fate);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
